// File: rtl/restoring_divider.sv
// ---------------------------------------------------------------------------
// restoring_divider
//   Sequential unsigned restoring divider: FSM controller plus A/Q/M/count
//   datapath. Produces one quotient bit per SHIFT/SUB/FIX iteration and holds
//   the result in DONE until the next start. Shares the start/done handshake
//   of the Booth multiplier.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request; sampled only in IDLE or DONE
//   dividend     unsigned dividend, captured in LOAD
//   divisor      unsigned divisor, captured in LOAD
//   quotient     Q register
//   remainder    low WIDTH bits of the partial remainder A
//   busy         high in LOAD, SHIFT, SUB and FIX
//   done         high only in DONE; results valid while high
//   div_by_zero  set when divisor==0 at LOAD, cleared at the next LOAD
// ---------------------------------------------------------------------------
module restoring_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_SUB,
      S_FIX,
      S_DONE
   } state_t;

   state_t           state;
   logic [WIDTH:0]   a_reg;   // signed partial remainder, one guard bit
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] m_reg;
   logic [CW-1:0]    count;
   logic             dbz_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         a_reg   <= '0;
         q_reg   <= '0;
         m_reg   <= '0;
         count   <= '0;
         dbz_reg <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) state <= S_LOAD;
            end

            S_LOAD: begin
               m_reg   <= divisor;
               count   <= CW'(WIDTH);
               dbz_reg <= (divisor == '0);
               if (divisor == '0) begin
                  // Divide by zero: skip iterations, report all-ones quotient
                  // and hand the dividend back as the remainder.
                  q_reg <= '1;
                  a_reg <= {1'b0, dividend};
                  state <= S_DONE;
               end else begin
                  q_reg <= dividend;
                  a_reg <= '0;
                  state <= S_SHIFT;
               end
            end

            S_SHIFT: begin
               // {A,Q} shifted left as one register; new Q[0] starts at 0.
               {a_reg, q_reg} <= {a_reg[WIDTH-1:0], q_reg, 1'b0};
               state          <= S_SUB;
            end

            S_SUB: begin
               a_reg <= a_reg - {1'b0, m_reg};
               state <= S_FIX;
            end

            S_FIX: begin
               if (a_reg[WIDTH]) begin
                  // Trial subtraction went negative: restore A, bit stays 0.
                  a_reg    <= a_reg + {1'b0, m_reg};
                  q_reg[0] <= 1'b0;
               end else begin
                  q_reg[0] <= 1'b1;
               end
               count <= count - CW'(1);
               if (count == CW'(1)) state <= S_DONE;
               else                 state <= S_SHIFT;
            end

            S_DONE: begin
               if (start) state <= S_LOAD;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   assign quotient    = q_reg;
   assign remainder   = a_reg[WIDTH-1:0];
   assign div_by_zero = dbz_reg;
   assign busy        = (state == S_LOAD) || (state == S_SHIFT) ||
                        (state == S_SUB)  || (state == S_FIX);
   assign done        = (state == S_DONE);

endmodule

// File: tb/tb_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_restoring_divider
//   Directed-vector bench for restoring_divider (WIDTH=8) with a short
//   random sweep checked against / and %.
// ---------------------------------------------------------------------------
module tb_restoring_divider;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       busy;
   logic       done;
   logic       div_by_zero;

   int n_tests = 0;
   int n_fail  = 0;

   restoring_divider #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Waits (bounded) for done after E0 and checks latency, busy length and results.
   task automatic finish_div(input string tag, input logic [7:0] eq, input logic [7:0] er,
                             input logic ez, input int elat);
      int lat;
      int bcnt;
      lat  = 0;
      bcnt = busy ? 1 : 0;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (busy) bcnt++;
         if (busy && done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_excl: busy and done both high", tag);
         end
      end
      check({tag, "_lat"},  lat,  elat);
      check({tag, "_busy"}, bcnt, elat);
      check({tag, "_q"},    quotient,    eq);
      check({tag, "_r"},    remainder,   er);
      check({tag, "_dbz"},  div_by_zero, ez);
   endtask

   // Starts a division one cycle from now and runs it to completion.
   task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic ez, input int elat, input bit full);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk); #1;   // E0
      start = 1'b0;
      if (full) begin
         check({tag, "_busy0"}, busy, 1'b1);
         check({tag, "_done0"}, done, 1'b0);
      end
      finish_div(tag, eq, er, ez, elat);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_q",    quotient,    8'd0);
      check("rst_r",    remainder,   8'd0);
      check("rst_busy", busy,        1'b0);
      check("rst_done", done,        1'b0);
      check("rst_dbz",  div_by_zero, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic and boundary vectors.
      run_div("d100_7",   8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 25, 1'b1);
      run_div("d5_9",     8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 25, 1'b1);
      run_div("d255_1",   8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 25, 1'b1);
      run_div("d255_255", 8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 25, 1'b1);
      run_div("d0_3",     8'd0,   8'd3,   8'd0,   8'd0,  1'b0, 25, 1'b1);

      // Divide by zero, then a normal op clears the flag.
      run_div("d42_0",    8'd42,  8'd0,   8'd255, 8'd42, 1'b1, 1,  1'b1);
      run_div("d10_3",    8'd10,  8'd3,   8'd3,   8'd1,  1'b0, 25, 1'b1);

      // Start pulse during an operation is ignored.
      dividend = 8'd200;
      divisor  = 8'd13;
      start    = 1'b1;
      @(posedge clk); #1;   // E0
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      dividend = 8'd50;
      divisor  = 8'd3;
      start    = 1'b1;
      @(posedge clk); #1;   // E5 samples start while busy
      start = 1'b0;
      begin : ignored_start
         int lat;
         lat = 5;
         while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
         end
         check("d200_13_lat", lat, 25);
         check("d200_13_q", quotient, 8'd15);
         check("d200_13_r", remainder, 8'd5);
      end
      @(posedge clk); #1;
      check("d200_13_hold", done, 1'b1);

      // Reset in the middle of an operation.
      dividend = 8'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      @(posedge clk); #1;   // E0
      start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_q",    quotient,    8'd0);
      check("mid_rst_r",    remainder,   8'd0);
      check("mid_rst_busy", busy,        1'b0);
      check("mid_rst_done", done,        1'b0);
      check("mid_rst_dbz",  div_by_zero, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_idle", busy, 1'b0);
      run_div("after_rst", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 25, 1'b1);

      // Back-to-back from DONE: start in the same cycle done is high.
      check("b2b_in_done", done, 1'b1);
      run_div("d77_8", 8'd77, 8'd8, 8'd9, 8'd5, 1'b0, 25, 1'b1);

      // Random sweep against a / and % reference.
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] a;
         logic [7:0] b;
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         if (b == 8'd0)
            run_div("rnd_z", a, b, 8'hFF, a, 1'b1, 1, 1'b0);
         else
            run_div("rnd", a, b, a / b, a % b, 1'b0, 25, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
